// File: rtl/som_bmu_search.sv
// som_bmu_search
// Best-matching-unit search for the SOM datapath. Element distances arrive
// one per beat from the vector element processor. VEC_LEN beats make up one
// neuron's distance, and a full scan covers NUM_NEURONS neurons. When the
// last beat of the scan is accepted, the block reports the index and the
// accumulated distance of the neuron with the smallest sum.
//
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   start       pulse that begins a search (honoured only when idle)
//   abs_dist    element distance from the VEP (unsigned, DIST_W bits)
//   dist_valid  abs_dist is valid this cycle
//   dist_ready  a beat is accepted this cycle if dist_valid is high (ACCUM only)
//   busy        a search is in progress (ACCUM or DONE)
//   done        one-cycle pulse; bmu_idx/bmu_dist are valid while it is high
//   bmu_idx     winning neuron index (held until the next result)
//   bmu_dist    winning accumulated distance (held until the next result)
module som_bmu_search #(
    parameter int NUM_NEURONS = 64,
    parameter int VEC_LEN     = 3,
    parameter int DIST_W      = 16,
    parameter int ACC_W       = 18,
    parameter int IDX_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIST_W-1:0] abs_dist,
    input  logic              dist_valid,
    output logic              dist_ready,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  bmu_idx,
    output logic [ACC_W-1:0]  bmu_dist
);

    localparam int EW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [ACC_W-1:0] ALL_ONES  = '1;
    localparam logic [EW-1:0]    ELEM_LAST = EW'(VEC_LEN - 1);
    localparam logic [IDX_W-1:0] NEUR_LAST = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t             state_q,    state_d;
    logic [EW-1:0]      elem_cnt_q, elem_cnt_d;
    logic [IDX_W-1:0]   neur_cnt_q, neur_cnt_d;
    logic [ACC_W-1:0]   acc_q,      acc_d;
    logic [ACC_W-1:0]   min_q,      min_d;
    logic [IDX_W-1:0]   min_idx_q,  min_idx_d;
    logic               done_q,     done_d;
    logic [IDX_W-1:0]   bmu_idx_q,  bmu_idx_d;
    logic [ACC_W-1:0]   bmu_dist_q, bmu_dist_d;

    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   sum_sat;
    logic               last_elem;
    logic               last_neur;
    logic               better;

    always_comb begin
        // One extra bit catches the carry; on overflow the sum pins at all-ones.
        sum_wide  = {1'b0, acc_q} + (ACC_W+1)'(abs_dist);
        sum_sat   = sum_wide[ACC_W] ? ALL_ONES : sum_wide[ACC_W-1:0];
        last_elem = (elem_cnt_q == ELEM_LAST);
        last_neur = (neur_cnt_q == NEUR_LAST);
        // Strict compare: ties keep the earlier index, and an all-ones sum
        // can never displace the all-ones starting minimum.
        better    = (sum_sat < min_q);

        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;
        neur_cnt_d = neur_cnt_q;
        acc_d      = acc_q;
        min_d      = min_q;
        min_idx_d  = min_idx_q;
        done_d     = 1'b0;
        bmu_idx_d  = bmu_idx_q;
        bmu_dist_d = bmu_dist_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ACCUM;
                    elem_cnt_d = '0;
                    neur_cnt_d = '0;
                    acc_d      = '0;
                    min_d      = ALL_ONES;
                    min_idx_d  = '0;
                end
            end
            S_ACCUM: begin
                if (dist_valid) begin
                    if (!last_elem) begin
                        acc_d      = sum_sat;
                        elem_cnt_d = elem_cnt_q + EW'(1);
                    end else begin
                        if (better) begin
                            min_d     = sum_sat;
                            min_idx_d = neur_cnt_q;
                        end
                        acc_d      = '0;
                        elem_cnt_d = '0;
                        neur_cnt_d = neur_cnt_q + IDX_W'(1);
                        if (last_neur) begin
                            // Result registers load with the post-compare
                            // minimum so they are already valid while done
                            // is high in the DONE cycle.
                            state_d    = S_DONE;
                            done_d     = 1'b1;
                            bmu_idx_d  = better ? neur_cnt_q : min_idx_q;
                            bmu_dist_d = better ? sum_sat : min_q;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            elem_cnt_q <= '0;
            neur_cnt_q <= '0;
            acc_q      <= '0;
            min_q      <= ALL_ONES;
            min_idx_q  <= '0;
            done_q     <= 1'b0;
            bmu_idx_q  <= '0;
            bmu_dist_q <= '0;
        end else begin
            state_q    <= state_d;
            elem_cnt_q <= elem_cnt_d;
            neur_cnt_q <= neur_cnt_d;
            acc_q      <= acc_d;
            min_q      <= min_d;
            min_idx_q  <= min_idx_d;
            done_q     <= done_d;
            bmu_idx_q  <= bmu_idx_d;
            bmu_dist_q <= bmu_dist_d;
        end
    end

    assign dist_ready = (state_q == S_ACCUM);
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign bmu_idx    = bmu_idx_q;
    assign bmu_dist   = bmu_dist_q;

endmodule

// File: tb/tb_som_bmu_search.sv
// Bench for som_bmu_search: a 4-neuron, 3-element configuration at the
// default 18-bit accumulator width, plus a 16-bit-accumulator copy on the
// same stimulus for saturation. Table rows carry hand-derived results.
// Random scans are scored against a model that sums each neuron
// arithmetically and picks the first strict minimum.
module tb_som_bmu_search;
    localparam int NN = 4;
    localparam int VL = 3;
    localparam int DW = 16;
    localparam int IW = 6;
    localparam int NB = NN * VL;

    logic clk = 1'b0;
    logic rst, start, dist_valid;
    logic [DW-1:0] abs_dist;

    logic          rdy_a, busy_a, done_a;
    logic [IW-1:0] idx_a;
    logic [17:0]   dist_a;
    logic          rdy_b, busy_b, done_b;
    logic [IW-1:0] idx_b;
    logic [15:0]   dist_b;

    int nchk = 0;
    int nerr = 0;

    logic [IW-1:0] prev_i, prev_i16;
    logic [17:0]   prev_d;
    logic [15:0]   prev_d16;

    always #5 clk = ~clk;

    som_bmu_search #(.NUM_NEURONS(NN), .VEC_LEN(VL), .DIST_W(DW), .ACC_W(18), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .abs_dist(abs_dist), .dist_valid(dist_valid),
        .dist_ready(rdy_a), .busy(busy_a), .done(done_a), .bmu_idx(idx_a), .bmu_dist(dist_a));

    som_bmu_search #(.NUM_NEURONS(NN), .VEC_LEN(VL), .DIST_W(DW), .ACC_W(16), .IDX_W(IW)) dut16 (
        .clk(clk), .rst(rst), .start(start), .abs_dist(abs_dist), .dist_valid(dist_valid),
        .dist_ready(rdy_b), .busy(busy_b), .done(done_b), .bmu_idx(idx_b), .bmu_dist(dist_b));

    typedef logic [DW-1:0] beats_t [NB];

    typedef struct {
        string         name;
        beats_t        d;
        int            gap;
        logic [IW-1:0] ei;
        logic [17:0]   ed;
        logic [IW-1:0] ei16;
        logic [15:0]   ed16;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Each neuron's distance is the plain sum of its elements, clamped to the
    // accumulator range. The winner is the first neuron whose sum is strictly
    // below everything seen so far, starting from an all-ones minimum.
    task automatic model(input beats_t d, input int accw,
                         output logic [IW-1:0] bi, output logic [17:0] bd);
        longint maxv, best, s;
        maxv = (64'd1 << accw) - 1;
        best = maxv;
        bi   = '0;
        for (int k = 0; k < NN; k++) begin
            s = 0;
            for (int e = 0; e < VL; e++) s += longint'(d[k*VL+e]);
            if (s > maxv) s = maxv;
            if (s < best) begin
                best = s;
                bi   = IW'(k);
            end
        end
        bd = best[17:0];
    endtask

    task automatic run(input string nm, input beats_t d, input int gap,
                       input logic [IW-1:0] ei, input logic [17:0] ed,
                       input logic [IW-1:0] ei16, input logic [15:0] ed16);
        int busy_n;
        bit early, badr;
        busy_n = 0;
        early  = 0;
        badr   = 0;
        @(negedge clk);
        start = 1'b1;
        dist_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (done_a || done_b) early = 1;
            if (!rdy_a || !rdy_b) badr = 1;
            if (busy_a) busy_n++;
            if (i == NB/2) begin
                chk({nm, " hold_idx"},    32'(idx_a),  32'(prev_i));
                chk({nm, " hold_dist"},   32'(dist_a), 32'(prev_d));
                chk({nm, " hold_dist16"}, 32'(dist_b), 32'(prev_d16));
            end
            dist_valid = 1'b1;
            abs_dist   = d[i];
            @(negedge clk);
            dist_valid = 1'b0;
            abs_dist   = DW'($urandom);
            if (i < NB-1) begin
                for (int g = 0; g < gap; g++) begin
                    if (done_a || done_b) early = 1;
                    if (!rdy_a || !rdy_b) badr = 1;
                    if (busy_a) busy_n++;
                    start = (g == 0);
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        end
        if (busy_a) busy_n++;
        chk({nm, " done"},       32'(done_a), 32'd1);
        chk({nm, " done16"},     32'(done_b), 32'd1);
        chk({nm, " idx"},        32'(idx_a),  32'(ei));
        chk({nm, " dist"},       32'(dist_a), 32'(ed));
        chk({nm, " idx16"},      32'(idx_b),  32'(ei16));
        chk({nm, " dist16"},     32'(dist_b), 32'(ed16));
        chk({nm, " busy_len"},   32'(busy_n), 32'(NB + gap*(NB-1) + 1));
        chk({nm, " early_done"}, 32'(early),  32'd0);
        chk({nm, " ready"},      32'(badr),   32'd0);
        @(negedge clk);
        chk({nm, " done_pulse"}, 32'({done_a, done_b}), 32'd0);
        chk({nm, " idle"},       32'({busy_a, rdy_a}),  32'd0);
        prev_i   = ei;
        prev_d   = ed;
        prev_i16 = ei16;
        prev_d16 = ed16;
    endtask

    initial begin
        beats_t        rd;
        logic [IW-1:0] mi, mi16;
        logic [17:0]   md, md16;
        int            mode;

        tbl[0] = '{"basic", '{16'h0100, 16'h0100, 16'h0100, 16'h0060, 16'h0060, 16'h0060,
                              16'h0200, 16'h0200, 16'h0100, 16'h0100, 16'h0080, 16'h0080},
                   0, 6'd1, 18'h00120, 6'd1, 16'h0120};
        tbl[1] = '{"tie",   '{16'h0080, 16'h0080, 16'h0100, 16'h0050, 16'h0050, 16'h0060,
                              16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0100},
                   0, 6'd1, 18'h00100, 6'd1, 16'h0100};
        tbl[2] = tbl[0];
        tbl[2].name = "stall";
        tbl[2].gap  = 2;
        tbl[3] = '{"sat",   '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                              16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                   0, 6'd0, 18'h2FFFD, 6'd0, 16'hFFFF};
        tbl[4] = '{"post_rst", '{16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'h0000,
                                 16'h0200, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0400},
                   1, 6'd1, 18'h00010, 6'd1, 16'h0010};

        rst = 1'b1;
        start = 1'b0;
        dist_valid = 1'b0;
        abs_dist = '0;
        prev_i = '0; prev_d = '0; prev_i16 = '0; prev_d16 = '0;
        repeat (2) @(negedge clk);
        chk("rst outputs", 32'({done_a, busy_a, rdy_a, done_b, busy_b, rdy_b}), 32'd0);
        chk("rst idx",     32'(idx_a),  32'd0);
        chk("rst dist",    32'(dist_a), 32'd0);
        rst = 1'b0;

        run(tbl[0].name, tbl[0].d, tbl[0].gap, tbl[0].ei, tbl[0].ed, tbl[0].ei16, tbl[0].ed16);

        // Beats offered while idle must be ignored and must not touch the result.
        for (int i = 0; i < 4; i++) begin
            dist_valid = 1'b1;
            abs_dist   = DW'($urandom_range(0, 16));
            @(negedge clk);
            chk("idle_beat", 32'({done_a, busy_a, rdy_a}), 32'd0);
        end
        dist_valid = 1'b0;
        chk("idle idx",  32'(idx_a),  32'(prev_i));
        chk("idle dist", 32'(dist_a), 32'(prev_d));

        for (int t = 1; t < 4; t++)
            run(tbl[t].name, tbl[t].d, tbl[t].gap, tbl[t].ei, tbl[t].ed, tbl[t].ei16, tbl[t].ed16);

        // Reset partway through a scan: outputs clear immediately, no done.
        run(tbl[0].name, tbl[0].d, 0, tbl[0].ei, tbl[0].ed, tbl[0].ei16, tbl[0].ed16);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dist_valid = 1'b1;
            abs_dist   = 16'h0100;
            @(negedge clk);
        end
        dist_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst idx",   32'(idx_a),  32'd0);
        chk("async_rst dist",  32'(dist_a), 32'd0);
        chk("async_rst flags", 32'({busy_a, rdy_a, done_a, busy_b}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_i = '0; prev_d = '0; prev_i16 = '0; prev_d16 = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_done", 32'({done_a, busy_a}), 32'd0);
        end

        run(tbl[4].name, tbl[4].d, tbl[4].gap, tbl[4].ei, tbl[4].ed, tbl[4].ei16, tbl[4].ed16);

        for (int r = 0; r < 20; r++) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < NB; i++) begin
                case (mode)
                    0:       rd[i] = DW'($urandom_range(0, 3) * 16'h40);
                    1:       rd[i] = DW'($urandom);
                    default: rd[i] = DW'($urandom_range(16'hC000, 16'hFFFF));
                endcase
            end
            model(rd, 18, mi, md);
            model(rd, 16, mi16, md16);
            run("rand", rd, $urandom_range(0, 2), mi, md, mi16, md16[15:0]);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    // Safety net so the run cannot hang on a design that never finishes.
    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/som_bmu_search.md
Name: som_bmu_search

Overview:
- Consumes per-element absolute distances from the vector element processor, one element per beat.
- Accumulates each neuron's distance over VEC_LEN elements and finds the minimum-distance neuron over a full scan (the best matching unit).
- Reports the winning index and distance to the SOM controller, which then drives weight update and shift scheduling.

Parameters:
- NUM_NEURONS, 64, neurons scanned per search.
- VEC_LEN, 3, elements per input vector (beats per neuron).
- DIST_W, 16, width of incoming abs_dist (8.8 fixed point).
- ACC_W, 18, accumulator and result width; must be at least DIST_W+clog2(VEC_LEN).
- IDX_W, 6, neuron index width; must be at least clog2(NUM_NEURONS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a search; honoured only in IDLE.
- abs_dist  in  DIST_W  element distance from the VEP.
- dist_valid  in  1  abs_dist is valid this cycle.
- dist_ready  out  1  block accepts a beat; high only in ACCUM.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse when the result is valid.
- bmu_idx  out  IDX_W  winning neuron index.
- bmu_dist  out  ACC_W  winning accumulated distance.

Behaviour:
- Reset values: done=0, busy=0, dist_ready=0, bmu_idx=0, bmu_dist=0. Internal state: FSM=IDLE, counters=0, acc=0, min=all-ones, min_idx=0.
- Reset is asynchronous mid-search: the search is abandoned and no done is issued.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 moves to ACCUM next cycle.
  - On that move: elem_cnt=0, neur_cnt=0, acc=0, min=all-ones, min_idx=0.
  - dist_valid is ignored.
- ACCUM:
  - A beat is accepted when dist_valid=1 (dist_ready is 1 throughout ACCUM).
  - Cycles with dist_valid=0 are stalls; all state holds.
  - Non-last element (elem_cnt<VEC_LEN-1): acc <= sat(acc+abs_dist), elem_cnt++.
  - Last element: sum = sat(acc+abs_dist) is formed combinationally.
  - If sum < min (strict): min <= sum, min_idx <= neur_cnt.
  - Then acc <= 0, elem_cnt <= 0, neur_cnt++.
  - Last element of neuron NUM_NEURONS-1: go to DONE; the comparison still applies on this beat.
- DONE (exactly one cycle): done=1, bmu_idx <= min_idx, bmu_dist <= min; then IDLE.
- Latency: done is high in the cycle after the final accepted beat. Minimum search length with no stalls is NUM_NEURONS*VEC_LEN+2 cycles from the start pulse.
- Outputs are registered. bmu_idx and bmu_dist hold their values after done until the next DONE, even across later starts.
- busy = (state != IDLE).
- start while busy is ignored and does not restart the search.
- Ties: strict less-than, so the lowest index among equal distances wins.
- All-ones distance:
  - A neuron whose sum equals all-ones never beats the initial min.
  - If every neuron saturates, bmu_idx=0 and bmu_dist=all-ones.
- Arithmetic: unsigned. abs_dist is zero-extended to ACC_W. Addition saturates at 2^ACC_W-1; no wrap-around.
- start and the first dist_valid in the same cycle: the beat is not accepted, because dist_ready is 0 in IDLE.

Test Plan:
- NUM_NEURONS=4, VEC_LEN=3. Start, then 12 back-to-back beats with neuron sums {0x0300, 0x0120, 0x0500, 0x0200} (e.g. 0x0060 ×3 for neuron 1) -> done in the cycle after beat 12, bmu_idx=1, bmu_dist=0x0120, busy high for 13 cycles.
- Tie: neuron sums {0x0200, 0x0100, 0x0100, 0x0300} -> bmu_idx=1, bmu_dist=0x0100.
- Stalls: the same stream as the first scenario with dist_valid low for 2 cycles between every beat -> identical result; done 1 cycle after the last beat; start pulses issued mid-search are ignored.
- Saturation: ACC_W=16 override, every abs_dist=0xFFFF -> each sum saturates at 0xFFFF; result bmu_idx=0, bmu_dist=0xFFFF.
- Reset mid-search: assert rst after 5 beats -> all outputs 0 asynchronously, no done. New search {0x0400, 0x0010, 0x0400, 0x0400} -> bmu_idx=1, bmu_dist=0x0010.
- Idle protocol: dist_valid pulses while IDLE change nothing. Outputs hold from the prior result through a second start until its DONE.
